// File: rtl/sram64_arbiter.sv
// rtl/sram64_arbiter.sv - shares the 64-bit SRAM port between fetch and data requesters
// Optional build macro SRAM64_ARB_RR_EN selects round-robin instead of fixed data priority.
module sram64_arbiter #(
    parameter int SRAM_AW  = 13,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [63:0]        if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [63:0]        if_rdata,
    input  logic               d_req,
    input  logic [7:0]         d_wea,
    input  logic [63:0]        d_addr,
    input  logic [63:0]        d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [63:0]        d_rdata,
    output logic               sram_en,
    output logic [7:0]         sram_wea,
    output logic [SRAM_AW-1:0] sram_addra,
    output logic [63:0]        sram_dina,
    input  logic [63:0]        sram_douta
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_t;

    rsp_t rsp_q;
    rsp_t rsp_d;
    logic if_win;

`ifdef SRAM64_ARB_RR_EN
    localparam logic LAST_IF = 1'b0;
    localparam logic LAST_D  = 1'b1;

    logic        last_q;
    logic [31:0] unused_max_wait;

    assign unused_max_wait = MAX_WAIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= LAST_IF;
        end else if (if_gnt) begin
            last_q <= LAST_IF;
        end else if (d_gnt) begin
            last_q <= LAST_D;
        end
    end

    // On contention the side that did not win last time goes next.
    assign if_win = (last_q == LAST_D);
`else
    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [WW-1:0] wait_q;

    // Counts consecutive lost fetch cycles; saturates so the force stays asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (!if_req || if_gnt) begin
            wait_q <= '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + WW'(1);
        end
    end

    assign if_win = (wait_q == WAIT_MAX);
`endif

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && (!d_req || if_win)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sram_en    = if_gnt | d_gnt;
        sram_wea   = '0;
        sram_addra = '0;
        sram_dina  = '0;
        if (if_gnt) begin
            sram_addra = if_addr[SRAM_AW+2:3];
        end else if (d_gnt) begin
            sram_wea   = d_wea;
            sram_addra = d_addr[SRAM_AW+2:3];
            sram_dina  = d_wdata;
        end
    end

    // Response tag: remembers who owns the read data arriving next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q <= RSP_NONE;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    always_comb begin
        rsp_d = RSP_NONE;
        if (if_gnt) begin
            rsp_d = RSP_IF;
        end else if (d_gnt && (d_wea == 8'h00)) begin
            rsp_d = RSP_D;
        end
    end

    always_comb begin
        if_rvalid = (rsp_q == RSP_IF);
        d_rvalid  = (rsp_q == RSP_D);
        if_rdata  = sram_douta;
        d_rdata   = sram_douta;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, if_addr[63:SRAM_AW+3], if_addr[2:0],
                                d_addr[63:SRAM_AW+3], d_addr[2:0]};

endmodule

// File: tb/tb_sram64_arbiter.sv
// tb/tb_sram64_arbiter.sv - scoreboard bench for sram64_arbiter
module tb_sram64_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        d_req = 1'b0;
    logic [7:0]  d_wea = '0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        sram_en;
    logic [7:0]  sram_wea;
    logic [12:0] sram_addra;
    logic [63:0] sram_dina;
    logic [63:0] sram_douta;
    logic [31:0] cyc = '0;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] cyc;
        int          side;
        logic [12:0] addr;
        logic [7:0]  wea;
        logic [63:0] din;
    } gnt_rec_t;

    typedef struct {
        logic [31:0] cyc;
        int          side;
        logic [63:0] data;
    } rsp_rec_t;

    gnt_rec_t gq[$];
    rsp_rec_t rq[$];

    sram64_arbiter #(.SRAM_AW(13), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_wea(d_wea), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_wea(sram_wea), .sram_addra(sram_addra),
        .sram_dina(sram_dina), .sram_douta(sram_douta)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Read data is a per-cycle signature so a stale or wrong-cycle read is visible.
    assign sram_douta = {32'hA5A5_0000, cyc};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic ir, input logic [63:0] ia,
                        input logic dr, input logic [7:0] dw, input logic [63:0] da,
                        input logic [63:0] dd, input int exp_side,
                        input logic [12:0] exp_addr, input bit exp_rsp);
        gnt_rec_t g;
        rsp_rec_t p;
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_wea = dw; d_addr = da; d_wdata = dd;
        if (exp_side != 0) begin
            g.cyc = cyc; g.side = exp_side; g.addr = exp_addr;
            g.wea = (exp_side == 2) ? dw : 8'h00;
            g.din = (exp_side == 2) ? dd : 64'h0;
            gq.push_back(g);
        end
        if (exp_rsp) begin
            p.cyc = cyc + 32'd1; p.side = exp_side;
            p.data = {32'hA5A5_0000, cyc + 32'd1};
            rq.push_back(p);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 0, 13'd0, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        gnt_rec_t g;
        rsp_rec_t p;
        chk("gnt_exclusive", {63'h0, if_gnt & d_gnt}, 64'h0);
        if (gq.size() != 0 && gq[0].cyc < cyc) begin
            chk("missing_grant_cycle", {32'h0, cyc}, {32'h0, gq[0].cyc});
            void'(gq.pop_front());
        end
        if (rq.size() != 0 && rq[0].cyc < cyc) begin
            chk("missing_rvalid_cycle", {32'h0, cyc}, {32'h0, rq[0].cyc});
            void'(rq.pop_front());
        end
        if (sram_en) begin
            if (gq.size() == 0) begin
                chk("unexpected_grant", {62'h0, d_gnt, if_gnt}, 64'h0);
            end else begin
                g = gq.pop_front();
                chk("grant_cycle", {32'h0, cyc}, {32'h0, g.cyc});
                chk("grant_side", {62'h0, d_gnt, if_gnt}, (g.side == 1) ? 64'h1 : 64'h2);
                chk("sram_addra", {51'h0, sram_addra}, {51'h0, g.addr});
                chk("sram_wea", {56'h0, sram_wea}, {56'h0, g.wea});
                chk("sram_dina", sram_dina, g.din);
            end
        end else begin
            chk("idle_grants", {62'h0, d_gnt, if_gnt}, 64'h0);
            chk("idle_pins", {sram_dina[31:0] | sram_dina[63:32], 11'h0, sram_wea, sram_addra},
                64'h0);
        end
        if (if_rvalid || d_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", {62'h0, d_rvalid, if_rvalid}, 64'h0);
            end else begin
                p = rq.pop_front();
                chk("rvalid_cycle", {32'h0, cyc}, {32'h0, p.cyc});
                chk("rvalid_side", {62'h0, d_rvalid, if_rvalid},
                    (p.side == 1) ? 64'h1 : 64'h2);
                chk("rdata", (p.side == 1) ? if_rdata : d_rdata, p.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[10];
        int ni;
        int nd;
        logic [63:0] ia;
        logic [63:0] da;
`ifdef SRAM64_ARB_RR_EN
        exp_seq = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1};
`else
        exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
`endif
        @(posedge clk);
        #1;
        chk("reset_if_rvalid", {63'h0, if_rvalid}, 64'h0);
        chk("reset_d_rvalid", {63'h0, d_rvalid}, 64'h0);
        chk("reset_sram_en", {63'h0, sram_en}, 64'h0);
        // Requests during reset must not be granted.
        step(1'b1, 1'b1, 64'h18, 1'b1, 8'h00, 64'h8, 64'h0, 0, 13'd0, 1'b0);

        // Lone fetch at 0x18 -> word 3.
        step(1'b0, 1'b1, 64'h18, 1'b0, 8'h00, 64'h0, 64'h0, 1, 13'd3, 1'b1);
        idle(1'b0);
        // Data write: 0x2A -> word 5, no response.
        step(1'b0, 1'b0, 64'h0, 1'b1, 8'h0C, 64'h2A, 64'h0000_0000_BEEF_0000, 2, 13'd5, 1'b0);
        idle(1'b0);
        // Back-to-back data reads at 0x00, 0x08, 0x10.
        step(1'b0, 1'b0, 64'h0, 1'b1, 8'h00, 64'h00, 64'h0, 2, 13'd0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1, 8'h00, 64'h08, 64'h0, 2, 13'd1, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1, 8'h00, 64'h10, 64'h0, 2, 13'd2, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // Reset mid-read: fetch granted, reset lands before its response edge.
        step(1'b0, 1'b1, 64'h38, 1'b0, 8'h00, 64'h0, 64'h0, 1, 13'd7, 1'b0);
        step(1'b1, 1'b1, 64'h38, 1'b1, 8'h00, 64'h0, 64'h0, 0, 13'd0, 1'b0);
        step(1'b1, 1'b1, 64'h38, 1'b1, 8'h00, 64'h0, 64'h0, 0, 13'd0, 1'b0);

        // Continuous contention out of reset, data reads.
        ni = 0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            ia = 64'h100 + 64'(ni * 8);
            da = 64'h40 + 64'(nd * 8);
            if (exp_seq[k] == 1) begin
                step(1'b0, 1'b1, ia, 1'b1, 8'h00, da, 64'h0, 1, ia[15:3], 1'b1);
                ni++;
            end else begin
                step(1'b0, 1'b1, ia, 1'b1, 8'h00, da, 64'h0, 2, da[15:3], 1'b1);
                nd++;
            end
        end
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        chk("grant_queue_drained", 64'(gq.size()), 64'h0);
        chk("rsp_queue_drained", 64'(rq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
